reg_scoreboard: RTL and testbench

- Tracks register-file writes that are in flight between issue (ID) and write-back (WB).
- Consumes the same write-back interface the register file receives (Dest_wb, writeBackEn).
- Tells ID whether an instruction's sources are still pending, so ID can stall instead of reading stale register contents.
- Sits beside the register file. It is updated on the rising clock edge. The register file writes on the falling edge.

---
 rtl/reg_scoreboard_pkg.sv | 13 +
 rtl/sb_counter.sv | 40 ++++
 rtl/reg_scoreboard.sv | 100 ++++++++++
 tb/tb_reg_scoreboard.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register scoreboard and its per-register counters.
package reg_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W   = 4;
    localparam int unsigned NUM_REGS_DEF = 16;
    localparam int unsigned INFLIGHT_W   = 5;

    // Architectural register indices with special roles.
    localparam logic [REG_ADDR_W-1:0] PC = 4'd15;
    localparam logic [REG_ADDR_W-1:0] LR = 4'd14;
    localparam logic [REG_ADDR_W-1:0] SP = 4'd13;

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one register: up on issue, down on write-back,
// holds at its limits and flags a write-back that finds it already empty.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: simultaneous inc and dec cancel; never wrap past either end.
    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
        end else if (dec && !inc) begin
            if (count_q != '0) count_d = count_q - CNT_ONE;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count     = count_q;
    assign nonzero   = (count_q != '0);
    assign underflow = dec && (count_q == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts writes in flight between issue and write-back
// and stalls ID while an instruction's sources (or its dest counter) are busy.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
    parameter int unsigned CNT_W     = 2,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_wb_en,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    input  logic [REG_ADDR_W-1:0] issue_src1,
    input  logic [REG_ADDR_W-1:0] issue_src2,
    input  logic                  issue_two_src,
    input  logic                  issue_kill,
    input  logic [REG_ADDR_W-1:0] Dest_wb,
    input  logic                  writeBackEn,
    output logic                  hazard,
    output logic                  issue_accept,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic [INFLIGHT_W-1:0] inflight,
    output logic                  err_underflow
);

    localparam int unsigned      ADDR_SPAN = 2 ** REG_ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Padded to the full address space so any 4-bit index reads a defined 0.
    logic [CNT_W-1:0]      cnt_ext [ADDR_SPAN];
    logic [NUM_REGS-1:0]   uflow_vec;
    logic                  inc;
    logic                  dec_eff;
    logic                  pend1, pend2, full;
    logic [INFLIGHT_W-1:0] inflight_q;
    logic                  err_q;

    assign inc     = issue_accept && issue_wb_en;
    // Padded entries read 0, so out-of-range write-backs never count here.
    assign dec_eff = writeBackEn && (cnt_ext[Dest_wb] != '0);

    for (genvar r = 0; r < ADDR_SPAN; r++) begin : g_reg
        if (r < NUM_REGS) begin : g_cnt
            logic inc_r, dec_r;
            assign inc_r = inc && (issue_dest == REG_ADDR_W'(r));
            assign dec_r = writeBackEn && (Dest_wb == REG_ADDR_W'(r));
            sb_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .inc      (inc_r),
                .dec      (dec_r),
                .count    (cnt_ext[r]),
                .nonzero  (pending_mask[r]),
                .underflow(uflow_vec[r])
            );
        end else begin : g_pad
            assign cnt_ext[r] = '0;
        end
    end

    // Source pending / dest-full checks against pre-increment counts.
    always_comb begin
        pend1 = (cnt_ext[issue_src1] != '0);
        pend2 = (cnt_ext[issue_src2] != '0);
        // Last outstanding write landing this cycle reaches the file before use.
        if (WB_BYPASS && writeBackEn && (Dest_wb == issue_src1) &&
            (cnt_ext[issue_src1] == CNT_ONE)) begin
            pend1 = 1'b0;
        end
        if (WB_BYPASS && writeBackEn && (Dest_wb == issue_src2) &&
            (cnt_ext[issue_src2] == CNT_ONE)) begin
            pend2 = 1'b0;
        end
        full = issue_wb_en && (cnt_ext[issue_dest] == CNT_MAX) &&
               !(writeBackEn && (Dest_wb == issue_dest));
        hazard       = !rst && issue_valid && (pend1 || (issue_two_src && pend2) || full);
        issue_accept = issue_valid && !hazard && !issue_kill;
    end

    // Total in-flight writes; only write-backs that find a pending entry count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inflight_q <= '0;
        else     inflight_q <= inflight_q + INFLIGHT_W'(inc) - INFLIGHT_W'(dec_eff);
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             err_q <= 1'b0;
        else if (|uflow_vec) err_q <= 1'b1;
    end

    assign inflight      = inflight_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench: directed scenarios then random traffic, compared to a
// behavioural model of per-register pending counts.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_wb_en, issue_two_src, issue_kill, writeBackEn;
    logic [3:0]  issue_dest, issue_src1, issue_src2, Dest_wb;
    logic        hazard, issue_accept, err_underflow;
    logic [15:0] pending_mask;
    logic [4:0]  inflight;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_cnt [16];
    int m_inflight;
    bit m_err;
    bit s_haz, s_acc;

    reg_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_wb_en  (issue_wb_en),
        .issue_dest   (issue_dest),
        .issue_src1   (issue_src1),
        .issue_src2   (issue_src2),
        .issue_two_src(issue_two_src),
        .issue_kill   (issue_kill),
        .Dest_wb      (Dest_wb),
        .writeBackEn  (writeBackEn),
        .hazard       (hazard),
        .issue_accept (issue_accept),
        .pending_mask (pending_mask),
        .inflight     (inflight),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        m_inflight = 0;
        m_err      = 1'b0;
    endtask

    // A source is busy if any write is outstanding, unless its only one lands now.
    function automatic bit m_pend(int s, bit wbe, int dwb);
        if (m_cnt[s] == 0) return 1'b0;
        if (wbe && dwb == s && m_cnt[s] == 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_regs();
        logic [15:0] em;
        for (int i = 0; i < 16; i++) em[i] = (m_cnt[i] != 0);
        check_eq("pending_mask", 32'(pending_mask), 32'(em));
        check_eq("inflight", 32'(inflight), 32'(m_inflight % 32));
        check_eq("err_underflow", 32'(err_underflow), 32'(m_err));
    endtask

    // Called at a falling edge: drive, check combinational outputs, clock, check state.
    task automatic step(input bit v, input bit we, input int d, input int s1, input int s2,
                        input bit two, input bit kill, input bit wbe, input int dwb);
        bit eh, ea, inc;
        int pre;
        issue_valid   = v;
        issue_wb_en   = we;
        issue_dest    = 4'(d);
        issue_src1    = 4'(s1);
        issue_src2    = 4'(s2);
        issue_two_src = two;
        issue_kill    = kill;
        writeBackEn   = wbe;
        Dest_wb       = 4'(dwb);
        #1;
        eh = v && (m_pend(s1, wbe, dwb) || (two && m_pend(s2, wbe, dwb)) ||
                   (we && m_cnt[d] == 3 && !(wbe && dwb == d)));
        ea = v && !eh && !kill;
        check_eq("hazard", 32'(hazard), 32'(eh));
        check_eq("issue_accept", 32'(issue_accept), 32'(ea));
        s_haz = hazard;
        s_acc = issue_accept;
        @(posedge clk);
        inc = ea && we;
        pre = m_cnt[dwb];
        if (wbe && pre == 0) m_err = 1'b1;
        m_inflight += (inc ? 1 : 0) - ((wbe && pre != 0) ? 1 : 0);
        if (!(inc && wbe && d == dwb)) begin
            if (inc && m_cnt[d] < 3) m_cnt[d]++;
            if (wbe && m_cnt[dwb] > 0) m_cnt[dwb]--;
        end
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        issue_valid = 1'b1; issue_wb_en = 1'b0; issue_dest = '0; issue_src1 = 4'd3;
        issue_src2 = '0; issue_two_src = 1'b0; issue_kill = 1'b0;
        writeBackEn = 1'b0; Dest_wb = '0;
        #1;
        check_eq("rst_hazard", 32'(hazard), 32'd0);
        check_regs();
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 3, 0, 0, 0, 0, 0);
        check_eq("post_rst_hazard", 32'(s_haz), 32'd0);

        // RAW on r5, cleared in the same cycle by write-back bypass.
        step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 5, 0, 0, 0, 0, 0);
        check_eq("raw_hazard", 32'(s_haz), 32'd1);
        step(1, 0, 0, 5, 0, 0, 0, 1, 5);
        check_eq("bypass_hazard", 32'(s_haz), 32'd0);
        check_eq("mask5_clear", 32'(pending_mask[5]), 32'd0);

        // Issue and write-back to r2 in one cycle leaves its count alone.
        step(1, 1, 2, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0, 1, 2);
        check_eq("mask2_held", 32'(pending_mask[2]), 32'd1);
        check_eq("inflight_same", 32'(inflight), 32'd1);

        // Saturate r7, then accept only alongside its write-back.
        for (int i = 0; i < 3; i++) step(1, 1, 7, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0, 0, 0, 0);
        check_eq("full_hazard", 32'(s_haz), 32'd1);
        check_eq("full_accept", 32'(s_acc), 32'd0);
        step(1, 1, 7, 0, 0, 0, 0, 1, 7);
        check_eq("full_wb_accept", 32'(s_acc), 32'd1);

        // Underflow on r9 is sticky.
        step(0, 0, 0, 0, 0, 0, 0, 1, 9);
        idle();
        check_eq("err_sticky", 32'(err_underflow), 32'd1);

        // Mid-cycle asynchronous reset, then a killed issue.
        step(1, 1, 4, 0, 0, 0, 0, 0, 0);
        step(1, 1, 4, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_regs();
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 4, 0, 0, 0, 1, 0, 0);
        check_eq("kill_no_inc", 32'(pending_mask[4]), 32'd0);

        // Random traffic on a narrow register window to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(99) < 70, $urandom_range(99) < 70, int'($urandom_range(7)),
                 int'($urandom_range(15)), int'($urandom_range(15)), $urandom_range(1) == 1,
                 $urandom_range(99) < 10, $urandom_range(99) < 50,
                 ($urandom_range(99) < 80) ? int'($urandom_range(7)) : int'($urandom_range(15)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
